// File: rtl/object_buffer_reader_if.sv
// object_buffer_reader_if
//   Bundles the object-buffer read port and the dispatch handshake of the
//   object buffer reader.
//   Ports (master = reader side):
//     frame_start    in   pulse, start reading a new frame
//     object_count   in   objects in the buffer for this frame
//     mem_rd_en      out  buffer read enable
//     mem_addr       out  buffer read address
//     mem_rdata      in   buffer data, valid the cycle after mem_rd_en
//     next_object    in   dispatcher level: all units finished current object
//     object_data    out  current object record
//     unit_start     out  one-cycle start pulse to every task unit
//     read_end       out  no further objects this frame
//     busy           out  reader is inside a frame
//     issued_count   out  objects issued this frame
interface object_buffer_reader_if #(
  parameter int UNITS     = 16,
  parameter int OBJ_WIDTH = 64,
  parameter int ADDR_W    = 8
);
  logic                 frame_start;
  logic [ADDR_W:0]      object_count;
  logic                 mem_rd_en;
  logic [ADDR_W-1:0]    mem_addr;
  logic [OBJ_WIDTH-1:0] mem_rdata;
  logic                 next_object;
  logic [OBJ_WIDTH-1:0] object_data;
  logic [UNITS-1:0]     unit_start;
  logic                 read_end;
  logic                 busy;
  logic [ADDR_W:0]      issued_count;

  modport master (
    input  frame_start, object_count, mem_rdata, next_object,
    output mem_rd_en, mem_addr, object_data, unit_start, read_end, busy,
           issued_count
  );

  modport slave (
    output frame_start, object_count, mem_rdata, next_object,
    input  mem_rd_en, mem_addr, object_data, unit_start, read_end, busy,
           issued_count
  );
endinterface

// File: rtl/object_buffer_reader.sv
// object_buffer_reader
//   Walks the per-frame object buffer and hands one object at a time to the
//   task units: fetch from the synchronous-read buffer, latch, broadcast with
//   a one-cycle start pulse, then wait for next_object before advancing.
//   After the last object the reader raises read_end and parks in DONE.
//   Ports:
//     clk   in  system clock
//     rst   in  synchronous active-high reset
//     bus   master side of object_buffer_reader_if (buffer + dispatch)
module object_buffer_reader #(
  parameter int UNITS     = 16,
  parameter int OBJ_WIDTH = 64,
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  object_buffer_reader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_START = 3'd3,
    S_HOLD  = 3'd4,
    S_WAIT  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e               state_q, state_d;
  logic [ADDR_W:0]      remaining_q, remaining_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [OBJ_WIDTH-1:0] object_data_q, object_data_d;
  logic [ADDR_W:0]      issued_q, issued_d;
  logic                 read_end_q, read_end_d;
  logic                 mem_rd_en_q, mem_rd_en_d;
  logic                 unit_start_q, unit_start_d;
  logic                 busy_q, busy_d;
  logic [ADDR_W:0]      count_clamped;

  // Next-state, datapath updates and next-cycle output decode.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    addr_d        = addr_q;
    object_data_d = object_data_q;
    issued_d      = issued_q;
    read_end_d    = read_end_q;
    count_clamped = (bus.object_count > DEPTH_C) ? DEPTH_C : bus.object_count;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.frame_start) begin
          remaining_d = count_clamped;
          issued_d    = '0;
          addr_d      = '0;
          if (count_clamped == '0) begin
            // Empty frame: nothing to issue, report end right away.
            state_d    = S_DONE;
            read_end_d = 1'b1;
          end else begin
            state_d    = S_FETCH;
            read_end_d = 1'b0;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        // Buffer read data is valid exactly one cycle after the read enable.
        object_data_d = bus.mem_rdata;
        state_d       = S_START;
      end
      S_START: begin
        issued_d    = issued_q + (ADDR_W+1)'(1);
        remaining_d = remaining_q - (ADDR_W+1)'(1);
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        // read_end rises on WAIT entry only, after units have dropped the
        // previous completion, so the dispatcher never sees a stale pair.
        state_d = S_WAIT;
        if (remaining_q == '0) begin
          read_end_d = 1'b1;
        end else begin
          read_end_d = read_end_q;
        end
      end
      S_WAIT: begin
        if (bus.next_object) begin
          if (remaining_q != '0) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered and aligned with the state they belong to.
    mem_rd_en_d  = (state_d == S_FETCH);
    unit_start_d = (state_d == S_START);
    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      remaining_q   <= '0;
      addr_q        <= '0;
      object_data_q <= '0;
      issued_q      <= '0;
      read_end_q    <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      unit_start_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      addr_q        <= addr_d;
      object_data_q <= object_data_d;
      issued_q      <= issued_d;
      read_end_q    <= read_end_d;
      mem_rd_en_q   <= mem_rd_en_d;
      unit_start_q  <= unit_start_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.mem_rd_en    = mem_rd_en_q;
  assign bus.mem_addr     = addr_q;
  assign bus.object_data  = object_data_q;
  assign bus.unit_start   = {UNITS{unit_start_q}};
  assign bus.read_end     = read_end_q;
  assign bus.busy         = busy_q;
  assign bus.issued_count = issued_q;

endmodule
